// File: rtl/mem_unit_mc.sv
// Unified instruction/data memory for the multicycle core with IR, OldPC, MDR
// and a boot loader that streams the program in and holds the core until done.
module mem_unit_mc #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Adr,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] PC,
  output logic [31:0] ReadData,
  output logic [31:0] Instr,
  output logic [31:0] OldPC,
  output logic [31:0] Data,
  input  logic        boot_valid,
  input  logic [31:0] boot_data,
  input  logic        boot_last,
  output logic        boot_ready,
  output logic        core_hold,
  output logic        misalign,
  output logic        oob,
  output logic        boot_ovf
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [31:0] LIMIT = 32'(DEPTH) << 2;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   boot_ptr;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   waddr;
  logic [31:0]     wdata;
  logic [31:0]     mem [DEPTH];
  logic            in_range;
  logic            aligned;
  logic            beat;
  logic            we;
  logic            ovf_set;

  assign idx        = Adr[AW+1:2];
  assign in_range   = Adr < LIMIT;
  assign aligned    = Adr[1:0] == 2'b00;
  assign boot_ready = state_q == BOOT;
  assign core_hold  = state_q == BOOT;
  assign beat       = boot_valid & boot_ready;
  assign ReadData   = in_range ? mem[idx] : '0;

  always_comb begin
    state_d = state_q;
    ovf_set = 1'b0;
    we      = 1'b0;
    waddr   = idx;
    wdata   = WD;
    unique case (state_q)
      BOOT: begin
        if (beat) begin
          we    = 1'b1;
          waddr = boot_ptr;
          wdata = boot_data;
          if (boot_last) begin
            state_d = RUN;
          end else if (boot_ptr == LAST) begin
            state_d = RUN;
            ovf_set = 1'b1;
          end
        end
      end
      RUN: begin
        we = MemWrite & aligned & in_range;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      boot_ptr <= '0;
      Instr    <= '0;
      OldPC    <= '0;
      Data     <= '0;
      misalign <= 1'b0;
      oob      <= 1'b0;
      boot_ovf <= 1'b0;
    end else begin
      state_q <= state_d;
      if (beat) boot_ptr <= boot_ptr + 1'b1;
      if (ovf_set) boot_ovf <= 1'b1;
      if (state_q == RUN) begin
        // read-before-write: IR/MDR see the word as it was before this edge
        Data <= ReadData;
        if (IRWrite) begin
          Instr <= ReadData;
          OldPC <= PC;
        end
        if (MemWrite && !aligned) misalign <= 1'b1;
        if (MemWrite && !in_range) oob <= 1'b1;
      end
    end
  end

  // array is deliberately not reset so a re-boot simply overwrites it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule
